// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared KNN constants, FSM state type and elaboration helpers
// Purpose : metric encodings, distance-engine FSM state enum, and the ceil-div /
//           clog2 helpers used to size beat counters and the accumulator.
// Ports   : none (package).
package knn_pkg;

   localparam logic METRIC_EUCLID    = 1'b0;
   localparam logic METRIC_MANHATTAN = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Smallest r with 2**r >= v; 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int x = v - 1; x > 0; x = x >> 1) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/distance_engine_if.sv
// rtl/distance_engine_if.sv - beat input / result output bundle of the distance engine
// Purpose : groups the input beat handshake (with metric/type side-band) and the
//           result handshake into one interface.
// Ports   : master drives metric, in_valid, training_data, input_data,
//           training_data_type, out_ready; slave drives in_ready, out_valid,
//           distance, data_type.
interface distance_engine_if #(
   parameter int W      = 32,
   parameter int LANES  = 2,
   parameter int TYPE_W = 2,
   parameter int ACC_W  = 68
);
   logic                  metric;
   logic                  in_valid;
   logic                  in_ready;
   logic [W*LANES-1:0]    training_data;
   logic [W*LANES-1:0]    input_data;
   logic [TYPE_W-1:0]     training_data_type;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_W-1:0]      distance;
   logic [TYPE_W-1:0]     data_type;

   modport master (
      output metric, in_valid, training_data, input_data, training_data_type, out_ready,
      input  in_ready, out_valid, distance, data_type
   );

   modport slave (
      input  metric, in_valid, training_data, input_data, training_data_type, out_ready,
      output in_ready, out_valid, distance, data_type
   );
endinterface

// File: rtl/distance_lane.sv
// rtl/distance_lane.sv - one feature lane: registered |t-x| and mask, metric select
// Purpose : pipeline stage 1 for one lane; registers the absolute difference and
//           lane mask on load, then forms d*d or d (zero when masked).
// Ports   : clk, rst_n (async active-low), load (beat accepted), lane_en (lane
//           carries a real feature), t / x (W-bit features), metric (latched
//           selection), contrib (2W-bit contribution of the registered beat).
module distance_lane
   import knn_pkg::*;
#(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           lane_en,
   input  logic [W-1:0]   t,
   input  logic [W-1:0]   x,
   input  logic           metric,
   output logic [2*W-1:0] contrib
);
   logic [W-1:0]   d_q;
   logic           en_q;
   logic [2*W-1:0] d_wide;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q  <= '0;
         en_q <= 1'b0;
      end else if (load) begin
         d_q  <= (t >= x) ? (t - x) : (x - t);
         en_q <= lane_en;
      end
   end

   assign d_wide = {{W{1'b0}}, d_q};

   always_comb begin
      contrib = '0;
      if (en_q) begin
         if (metric == METRIC_MANHATTAN) contrib = d_wide;
         else                            contrib = d_wide * d_wide;
      end
   end
endmodule

// File: rtl/distance_engine.sv
// rtl/distance_engine.sv - streaming pipelined squared-Euclidean / Manhattan distance unit
// Purpose : accepts BEATS beats of LANES feature pairs, accumulates the selected
//           metric through a 3-stage pipeline and presents one tagged distance.
// Ports   : clk, rst_n (async active-low), clear (synchronous abort),
//           bus (distance_engine_if.slave: beat input and result output).
module distance_engine
   import knn_pkg::*;
#(
   parameter int M      = 2,
   parameter int N      = 4,
   parameter int W      = 32,
   parameter int LANES  = 2,
   parameter int TYPE_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   distance_engine_if.slave  bus
);
   localparam int F      = M * N;
   localparam int BEATS  = ceil_div(F, LANES);
   localparam int ACC_W  = 2 * W + clog2(F) + 1;
   localparam int BEAT_W = clog2(BEATS) + 1;

   state_t             state;
   logic [BEAT_W-1:0]  beat_cnt;
   logic [BEAT_W-1:0]  beat_idx;
   logic               metric_q;
   logic [TYPE_W-1:0]  type_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic [ACC_W-1:0]   dist_q;
   logic [TYPE_W-1:0]  dtype_q;
   logic               hs;

   logic               s1_valid;
   logic               s2_valid;
   logic [ACC_W-1:0]   lane_sum;
   logic [ACC_W-1:0]   s2_sum;
   logic [ACC_W-1:0]   acc;
   logic [LANES-1:0]   lane_en;
   logic [2*W-1:0]     contrib [LANES];

   assign hs       = bus.in_valid && in_ready_q;
   // The first beat is taken in IDLE, where beat_cnt has not yet advanced.
   assign beat_idx = (state == ST_IDLE) ? '0 : beat_cnt;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      // Lanes past the last feature on the final beat contribute nothing.
      assign lane_en[k] = (int'(beat_idx) * LANES + k) < F;

      distance_lane #(.W(W)) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (hs),
         .lane_en (lane_en[k]),
         .t       (bus.training_data[k*W +: W]),
         .x       (bus.input_data[k*W +: W]),
         .metric  (metric_q),
         .contrib (contrib[k])
      );
   end

   always_comb begin
      lane_sum = '0;
      for (int k = 0; k < LANES; k++) lane_sum = lane_sum + ACC_W'(contrib[k]);
   end

   // Stage 2 (lane sum) and stage 3 (accumulate).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s2_sum   <= '0;
         acc      <= '0;
      end else if (clear) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= hs;
         s2_valid <= s1_valid;
         if (s1_valid) s2_sum <= lane_sum;
         if (s2_valid) acc <= acc + s2_sum;
         // Previous vector has fully drained before IDLE, so no add is lost here.
         if (hs && state == ST_IDLE) acc <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         beat_cnt    <= '0;
         metric_q    <= METRIC_EUCLID;
         type_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         dist_q      <= '0;
         dtype_q     <= '0;
      end else if (clear) begin
         state       <= ST_IDLE;
         beat_cnt    <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               if (hs) begin
                  metric_q <= bus.metric;
                  type_q   <= bus.training_data_type;
                  beat_cnt <= BEAT_W'(1);
                  if (BEATS == 1) begin
                     state      <= ST_DRAIN;
                     in_ready_q <= 1'b0;
                  end else begin
                     state <= ST_ACCUM;
                  end
               end
            end
            ST_ACCUM: begin
               if (hs) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == BEAT_W'(BEATS - 1)) begin
                     state      <= ST_DRAIN;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            ST_DRAIN: begin
               // Both stage valids low means the last beat has reached acc.
               if (!s1_valid && !s2_valid) begin
                  state       <= ST_OUT;
                  out_valid_q <= 1'b1;
                  dist_q      <= acc;
                  dtype_q     <= type_q;
               end
            end
            ST_OUT: begin
               if (bus.out_ready) begin
                  state       <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  beat_cnt    <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.distance  = dist_q;
   assign bus.data_type = dtype_q;
endmodule

// File: tb/tb_distance_engine.sv
// tb/tb_distance_engine.sv - self-checking bench for distance_engine (LANES=3 and LANES=2)
module tb_distance_engine;
   import knn_pkg::*;

   localparam int W  = 32;
   localparam int M  = 2;
   localparam int N  = 4;
   localparam int F  = M * N;
   localparam int TW = 2;
   localparam int AW = 2 * W + 3 + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic clr0, clr1;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ncmp = 0;
   int nfail = 0;

   distance_engine_if #(.W(W), .LANES(3), .TYPE_W(TW), .ACC_W(AW)) b0 ();
   distance_engine_if #(.W(W), .LANES(2), .TYPE_W(TW), .ACC_W(AW)) b1 ();

   distance_engine #(.M(M), .N(N), .W(W), .LANES(3), .TYPE_W(TW)) dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clr0), .bus(b0.slave));
   distance_engine #(.M(M), .N(N), .W(W), .LANES(2), .TYPE_W(TW)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clr1), .bus(b1.slave));

   logic [W-1:0]  ft [F];
   logic [W-1:0]  fx [F];
   logic [AW-1:0] eq0 [$];
   logic [AW-1:0] eq1 [$];
   logic [TW-1:0] et0 [$];
   logic [TW-1:0] et1 [$];
   int lat0 = 0, lat1 = 0, first0 = 0, first1 = 0;
   bit pv0 = 0, pv1 = 0;

   task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      ncmp++;
      nfail++;
      $display("FAIL %s: bound expired", nm);
   endtask

   // Reference: sum over all features of |t-x| (Manhattan) or |t-x|^2.
   function automatic logic [AW-1:0] model(input bit met);
      logic [AW-1:0] s, d;
      s = '0;
      for (int i = 0; i < F; i++) begin
         d = (ft[i] > fx[i]) ? AW'(ft[i] - fx[i]) : AW'(fx[i] - ft[i]);
         s = s + (met ? d : d * d);
      end
      return s;
   endfunction

   task automatic fill(input logic [W-1:0] t, input logic [W-1:0] x);
      for (int i = 0; i < F; i++) begin
         ft[i] = t;
         fx[i] = x;
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < F; i++) begin
         ft[i] = $urandom;
         fx[i] = $urandom;
      end
   endtask

   task automatic set_lane(input int sel, input int k, input logic [W-1:0] tv, input logic [W-1:0] xv);
      if (sel == 0) begin
         b0.training_data[k*W +: W] = tv;
         b0.input_data[k*W +: W]    = xv;
      end else begin
         b1.training_data[k*W +: W] = tv;
         b1.input_data[k*W +: W]    = xv;
      end
   endtask

   task automatic set_ctl(input int sel, input bit v, input bit met, input logic [TW-1:0] typ);
      if (sel == 0) begin
         b0.in_valid = v; b0.metric = met; b0.training_data_type = typ;
      end else begin
         b1.in_valid = v; b1.metric = met; b1.training_data_type = typ;
      end
   endtask

   // Drives nsend beats (all beats = whole vector) starting at a negedge.
   // Later beats carry the inverted metric/type, which must be ignored.
   task automatic send(input int sel, input bit met, input logic [TW-1:0] typ,
                       input int max_bub, input int nsend);
      int lanes, beats, nb, idx, w;
      bit rdy;
      lanes = (sel == 0) ? 3 : 2;
      beats = (F + lanes - 1) / lanes;
      for (int b = 0; b < nsend; b++) begin
         nb = (max_bub > 0) ? int'($urandom_range(max_bub, 0)) : 0;
         for (int i = 0; i < nb; i++) begin
            set_ctl(sel, 1'b0, ~met, ~typ);
            for (int k = 0; k < lanes; k++) set_lane(sel, k, $urandom, $urandom);
            @(negedge clk);
         end
         for (int k = 0; k < lanes; k++) begin
            idx = b * lanes + k;
            if (idx < F) set_lane(sel, k, ft[idx], fx[idx]);
            else         set_lane(sel, k, 32'hFFFF_FFFF, 32'h0);
         end
         set_ctl(sel, 1'b1, (b == 0) ? met : ~met, (b == 0) ? typ : ~typ);
         w = 0;
         rdy = (sel == 0) ? b0.in_ready : b1.in_ready;
         while (!rdy && w < 100) begin
            @(negedge clk);
            w++;
            rdy = (sel == 0) ? b0.in_ready : b1.in_ready;
         end
         if (!rdy) begin
            fail_now($sformatf("accept_beat%0d_dut%0d", b, sel));
            set_ctl(sel, 1'b0, met, typ);
            return;
         end
         @(posedge clk);
         #1;
         if (sel == 0) begin lat0 = cyc; if (b == 0) first0 = cyc; end
         else          begin lat1 = cyc; if (b == 0) first1 = cyc; end
         @(negedge clk);
         set_ctl(sel, 1'b0, met, typ);
      end
      if (nsend == beats) begin
         if (sel == 0) begin eq0.push_back(model(met)); et0.push_back(typ); end
         else          begin eq1.push_back(model(met)); et1.push_back(typ); end
      end
   endtask

   task automatic wait_out(input int sel);
      int w;
      w = 0;
      while (!((sel == 0) ? b0.out_valid : b1.out_valid) && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) fail_now($sformatf("wait_out_dut%0d", sel));
   endtask

   task automatic drain(input int sel);
      int w;
      w = 0;
      while (((sel == 0) ? eq0.size() : eq1.size()) != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w >= 200) fail_now($sformatf("drain_dut%0d", sel));
      @(negedge clk);
   endtask

   // Compare processes: every cycle a result is presented it must match the
   // oldest expected vector, in_ready must be low, and it must appear exactly
   // three edges after the accepting edge of the last beat.
   always @(negedge clk) begin
      if (!rst_n) pv0 = 1'b0;
      else begin
         if (b0.out_valid) begin
            if (eq0.size() == 0) begin
               ncmp++; nfail++;
               $display("FAIL out0_unexpected: got out_valid=1 distance=%0d, expected no result", b0.distance);
            end else begin
               chk("dist0", b0.distance, eq0[0]);
               chk("type0", AW'(b0.data_type), AW'(et0[0]));
               chk("inrdy0_in_out", AW'(b0.in_ready), AW'(0));
               if (!pv0) chk("latency0", AW'(cyc), AW'(lat0 + 3));
            end
         end
         pv0 = b0.out_valid;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) pv1 = 1'b0;
      else begin
         if (b1.out_valid) begin
            if (eq1.size() == 0) begin
               ncmp++; nfail++;
               $display("FAIL out1_unexpected: got out_valid=1 distance=%0d, expected no result", b1.distance);
            end else begin
               chk("dist1", b1.distance, eq1[0]);
               chk("type1", AW'(b1.data_type), AW'(et1[0]));
               chk("inrdy1_in_out", AW'(b1.in_ready), AW'(0));
               if (!pv1) chk("latency1", AW'(cyc), AW'(lat1 + 3));
            end
         end
         pv1 = b1.out_valid;
      end
   end

   always @(posedge clk) begin
      if (!rst_n || clr0) begin
         eq0.delete(); et0.delete();
      end else if (b0.out_valid && b0.out_ready && eq0.size() > 0) begin
         void'(eq0.pop_front()); void'(et0.pop_front());
      end
      if (!rst_n || clr1) begin
         eq1.delete(); et1.delete();
      end else if (b1.out_valid && b1.out_ready && eq1.size() > 0) begin
         void'(eq1.pop_front()); void'(et1.pop_front());
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int f1;
      logic [AW-1:0] max_exp;
      rst_n = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
      set_ctl(0, 1'b0, 1'b0, '0); set_ctl(1, 1'b0, 1'b0, '0);
      b0.training_data = '0; b0.input_data = '0; b0.out_ready = 1'b1;
      b1.training_data = '0; b1.input_data = '0; b1.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_inrdy0", AW'(b0.in_ready), AW'(0));
      chk("rst_oval0",  AW'(b0.out_valid), AW'(0));
      chk("rst_dist0",  b0.distance, AW'(0));
      chk("rst_type0",  AW'(b0.data_type), AW'(0));
      chk("rst_inrdy1", AW'(b1.in_ready), AW'(0));
      chk("rst_oval1",  AW'(b1.out_valid), AW'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_inrdy0", AW'(b0.in_ready), AW'(1));
      chk("post_rst_inrdy1", AW'(b1.in_ready), AW'(1));
      @(negedge clk);

      // Hand-computed pins for the reference model.
      fill(32'd1, 32'd0);  chk("model_ones", model(METRIC_EUCLID), AW'(8));
      fill(32'd5, 32'd2);  chk("model_man", model(METRIC_MANHATTAN), AW'(24));
                           chk("model_euc", model(METRIC_EUCLID), AW'(72));
      max_exp = AW'(64'hFFFF_FFFE_0000_0001) << 3;
      fill(32'hFFFF_FFFF, 32'd0); chk("model_max", model(METRIC_EUCLID), max_exp);

      // Basic vectors on both lane widths.
      fill(32'd1, 32'd0);
      send(0, METRIC_EUCLID, 2'd2, 0, 3); drain(0);
      send(1, METRIC_EUCLID, 2'd2, 0, 4); drain(1);

      // Back-to-back Manhattan then Euclidean; checks throughput BEATS+4.
      fill(32'd5, 32'd2);
      send(0, METRIC_MANHATTAN, 2'd1, 0, 3); f1 = first0;
      send(0, METRIC_EUCLID,    2'd3, 0, 3);
      chk("throughput0", AW'(first0 - f1), AW'(7));
      drain(0);
      send(1, METRIC_MANHATTAN, 2'd1, 0, 4); f1 = first1;
      send(1, METRIC_EUCLID,    2'd3, 0, 4);
      chk("throughput1", AW'(first1 - f1), AW'(8));
      drain(1);

      // All-max inputs: no wrap.
      fill(32'hFFFF_FFFF, 32'd0);
      send(0, METRIC_EUCLID, 2'd0, 0, 3); drain(0);
      send(1, METRIC_EUCLID, 2'd0, 0, 4); drain(1);

      // Backpressure: result held 10 cycles, offered beats ignored.
      fill(32'd9, 32'd100);
      b0.out_ready = 1'b0;
      send(0, METRIC_MANHATTAN, 2'd1, 0, 3);
      wait_out(0);
      for (int i = 0; i < 10; i++) begin
         set_ctl(0, 1'b1, 1'b0, 2'd3);
         set_lane(0, 0, $urandom, $urandom);
         @(negedge clk);
      end
      set_ctl(0, 1'b0, 1'b0, 2'd0);
      chk("hold_pending0", AW'(eq0.size()), AW'(1));
      b0.out_ready = 1'b1;
      drain(0);

      // Random values with bubbles, both metrics, both lane widths.
      for (int s = 0; s < 2; s++) begin
         for (int v = 0; v < 4; v++) begin
            fill_rand();
            send(s, v[0], TW'(v), 3, (s == 0) ? 3 : 4);
         end
         drain(s);
      end

      // Reset after beat 2, then a clean vector.
      fill(32'd7, 32'd3);
      send(0, METRIC_EUCLID, 2'd2, 0, 2);
      rst_n = 1'b0;
      #1;
      chk("midrst_inrdy0", AW'(b0.in_ready), AW'(0));
      chk("midrst_oval0",  AW'(b0.out_valid), AW'(0));
      chk("midrst_dist0",  b0.distance, AW'(0));
      chk("midrst_type0",  AW'(b0.data_type), AW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(0, METRIC_MANHATTAN, 2'd3, 1, 3); drain(0);

      // Clear in ACCUM, then a clean vector.
      fill(32'd20, 32'd10);
      send(0, METRIC_EUCLID, 2'd1, 0, 2);
      clr0 = 1'b1;
      @(negedge clk);
      clr0 = 1'b0;
      chk("clr_accum_inrdy0", AW'(b0.in_ready), AW'(1));
      chk("clr_accum_oval0",  AW'(b0.out_valid), AW'(0));
      fill(32'd3, 32'd8);
      send(0, METRIC_EUCLID, 2'd2, 0, 3); drain(0);

      // Clear in OUT together with out_ready: result discarded.
      b0.out_ready = 1'b0;
      send(0, METRIC_MANHATTAN, 2'd1, 0, 3);
      wait_out(0);
      b0.out_ready = 1'b1;
      clr0 = 1'b1;
      @(negedge clk);
      clr0 = 1'b0;
      chk("clr_out_oval0",  AW'(b0.out_valid), AW'(0));
      chk("clr_out_inrdy0", AW'(b0.in_ready), AW'(1));
      fill(32'd1, 32'd4);
      send(0, METRIC_EUCLID, 2'd0, 0, 3); drain(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
